alu_src_sel_reg: RTL
====================

ALU_SRC_SEL_REG -- requirements
Module: alu_src_sel_reg

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter NUM_SRC, default 5, number of selectable sources (2..16).
REQ-003 Parameter CONST_IDX, default 1, source index replaced by the constant CONST_VAL; a value >= NUM_SRC disables constant replacement.
REQ-004 Parameter CONST_VAL, default 4, WIDTH-bit constant driven when sel == CONST_IDX.
REQ-005 Derived constant SEL_W = max(1, clog2(NUM_SRC)); not user-overridden.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 src_flat  input  NUM_SRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH]; the slice at CONST_IDX is ignored.
REQ-009 sel  input  SEL_W  source select, sampled only on an accepted beat.
REQ-010 in_valid  input  1  upstream presents sel/src_flat.
REQ-011 in_ready  output  1  block can accept a beat this cycle.
REQ-012 out_data  output  WIDTH  selected operand, registered.
REQ-013 out_valid  output  1  out_data holds an undelivered operand.
REQ-014 out_ready  input  1  ALU consumes out_data this cycle.
REQ-015 sel_err  output  1  sticky flag: an accepted beat carried sel >= NUM_SRC.
REQ-016 err_clear  input  1  synchronous clear of sel_err.

Function
REQ-017 Accept = in_valid & in_ready; deliver = out_valid & out_ready; both evaluated on the same rising edge.
REQ-018 Selected value: CONST_VAL if sel == CONST_IDX; else the source slice if sel < NUM_SRC; else all zeros.
REQ-019 Selection is fully combinational over all sel codes with no inferred latch; the value is captured only on accept.
REQ-020 Storage is a two-entry in-order buffer with states EMPTY, ONE, TWO; out_data always shows the oldest entry.
REQ-021 EMPTY: accept -> ONE; no accept -> EMPTY; deliver is impossible (out_valid = 0).
REQ-022 ONE: accept only -> TWO; deliver only -> EMPTY; accept and deliver together -> ONE with the new value at head.
REQ-023 TWO: deliver -> ONE with the second entry promoted to head; no deliver -> TWO; accept is impossible.
REQ-024 in_ready = 1 in EMPTY and ONE, 0 in TWO; driven from a register or state decode, with no combinational path from out_ready.
REQ-025 out_valid = 1 in ONE and TWO; latency from accept to out_valid = 1 cycle when the buffer was EMPTY.
REQ-026 out_data is stable while out_valid = 1 and out_ready = 0.
REQ-027 sel_err sets on an accepted beat with sel >= NUM_SRC; that beat is still enqueued with zero data.
REQ-028 err_clear clears sel_err; if set and clear occur in the same cycle, set wins.
REQ-029 sel >= NUM_SRC with in_valid = 0, or while in_ready = 0, does not set sel_err.

Reset
REQ-030 reset asserted: state = EMPTY, out_valid = 0, out_data = 0, both entries = 0, sel_err = 0, in_ready = 1, all immediately, independent of clk.
REQ-031 Reset mid-transfer discards all buffered operands; no beat is delivered after reset deassertion until a new accept occurs.

Structure
REQ-032 Buffer state encoding (EMPTY/ONE/TWO) and the default WIDTH/NUM_SRC/CONST values belong in the shared CPU package, alongside the other mux select encodings.
REQ-033 One sub-module, src_sel_comb (the REQ-018 selector), is instantiated once; the buffer and state machine stay in the top module.

Verification
REQ-034 Defaults; reset; in_valid = 1 with sel = 1 and out_ready = 1 -> next cycle out_data = 4, out_valid = 1.
REQ-035 sel = 0, src0 = 0xDEADBEEF, out_ready = 0 for 3 cycles, then a second beat with sel = 4, src4 = 0x12345678 -> after two accepts in_ready = 0; out_data holds 0xDEADBEEF; on out_ready = 1 the outputs are 0xDEADBEEF then 0x12345678, in order.
REQ-036 sel = 7 accepted -> out_data = 0 and sel_err = 1 on the next cycle; err_clear for 1 cycle -> sel_err = 0; err_clear together with another sel = 7 accept -> sel_err stays 1.
REQ-037 Buffer in ONE with out_ready = 1 and in_valid = 1 on every cycle for 10 cycles using sel = 3 -> one operand delivered per cycle; in_ready is never 0.
REQ-038 reset asserted asynchronously while in TWO -> out_valid = 0, in_ready = 1 and out_data = 0 before the next clk edge.
REQ-039 Repeat REQ-034 to REQ-036 with WIDTH = 16, NUM_SRC = 3, CONST_IDX = 3 -> no constant substitution; sel = 3 yields zero data and sets sel_err.

Source files
------------

// File: rtl/alu_src_sel_reg_pkg.sv
// Shared CPU mux package: buffer state encoding, default operand-select
// parameters and the select-width helper used by the ALU source register.
package alu_src_sel_reg_pkg;

   // Occupancy of the two-entry operand buffer.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_NUM_SRC   = 5;
   localparam int DEF_CONST_IDX = 1;
   localparam int DEF_CONST_VAL = 4;

   // Select width never drops below one bit, even for two sources.
   function automatic int sel_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_src_sel_reg_src_sel_comb.sv
// Purely combinational operand selector. One source index may be replaced
// by a constant; out-of-range codes yield zero and raise sel_bad.
module src_sel_comb
   import alu_src_sel_reg_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               NUM_SRC   = DEF_NUM_SRC,
   parameter int               CONST_IDX = DEF_CONST_IDX,
   parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEF_CONST_VAL),
   parameter int               SEL_W     = sel_width(NUM_SRC)
) (
   input  logic [NUM_SRC*WIDTH-1:0] src_flat,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         sel_data,
   output logic                     sel_bad
);

   // Walk every legal index; anything unmatched falls through to zero/bad.
   always_comb begin
      sel_data = '0;
      sel_bad  = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_bad  = 1'b0;
            sel_data = (k == CONST_IDX) ? CONST_VAL : src_flat[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/alu_src_sel_reg.sv
// ALU operand source select with a two-entry in-order output buffer.
//
// Handshake: a beat moves on a rising edge only when valid and ready are
// both high on that edge (accept = in_valid & in_ready, deliver =
// out_valid & out_ready). Ready never depends combinationally on valid,
// and in_ready is a pure decode of the buffer state.
module alu_src_sel_reg
   import alu_src_sel_reg_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               NUM_SRC   = DEF_NUM_SRC,
   parameter int               CONST_IDX = DEF_CONST_IDX,
   parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEF_CONST_VAL),
   localparam int              SEL_W     = sel_width(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src_flat,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sel_err,
   input  logic                     err_clear,
   output buf_state_t               state_dbg
);

   buf_state_t       state, state_nxt;
   logic [WIDTH-1:0] head, tail;
   logic [WIDTH-1:0] sel_data;
   logic             sel_bad;
   logic             accept, deliver;

   src_sel_comb #(
      .WIDTH     (WIDTH),
      .NUM_SRC   (NUM_SRC),
      .CONST_IDX (CONST_IDX),
      .CONST_VAL (CONST_VAL),
      .SEL_W     (SEL_W)
   ) u_sel (
      .src_flat (src_flat),
      .sel      (sel),
      .sel_data (sel_data),
      .sel_bad  (sel_bad)
   );

   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;
   assign out_data  = head;
   assign state_dbg = state;

   // Buffer occupancy register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= BUF_EMPTY;
      else       state <= state_nxt;
   end

   // Occupancy transitions from the accept/deliver pair.
   always_comb begin
      state_nxt = state;
      case (state)
         BUF_EMPTY: if (accept) state_nxt = BUF_ONE;
         BUF_ONE: begin
            if (accept && !deliver)      state_nxt = BUF_TWO;
            else if (!accept && deliver) state_nxt = BUF_EMPTY;
         end
         BUF_TWO:   if (deliver) state_nxt = BUF_ONE;
         default:   state_nxt = BUF_EMPTY;
      endcase
   end

   // Handshake outputs decoded from state only.
   always_comb begin
      in_ready  = (state != BUF_TWO);
      out_valid = (state != BUF_EMPTY);
   end

   // Entry storage: head is always the oldest operand.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
      end else begin
         case (state)
            BUF_EMPTY: if (accept) head <= sel_data;
            BUF_ONE: begin
               if (accept && deliver) head <= sel_data;
               else if (accept)       tail <= sel_data;
            end
            BUF_TWO:   if (deliver) head <= tail;
            default: ;
         endcase
      end
   end

   // Sticky select error; a new error outranks a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  sel_err <= 1'b0;
      else if (accept && sel_bad) sel_err <= 1'b1;
      else if (err_clear)         sel_err <= 1'b0;
   end

endmodule
